// File: rtl/arb_requester.sv
// ---------------------------------------------------------------------------
// arb_requester
//
// Purpose:
//   Requester-side agent for a two-port req/gnt arbiter. Local logic offers a
//   burst job (job_len+1 beats). The block raises req, waits for gnt, issues
//   one beat per granted cycle until the burst is complete, then drops req for
//   a fixed gap before it accepts another job. If no grant arrives within
//   MAX_WAIT cycles, the request is abandoned and a one-cycle error pulse is
//   raised.
//
// Parameters:
//   LEN_W     width of job_len; a burst is 1..2^LEN_W beats
//   MAX_WAIT  cycles spent in REQ without a grant before timeout (>= 2)
//   GAP       cycles req is held low after a burst or timeout (>= 1)
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   job_valid    in   local job offered
//   job_len      in   beats-1 of the offered job
//   job_ready    out  job can be accepted (state is IDLE)
//   req          out  registered request to the arbiter
//   gnt          in   grant from the arbiter (lags req by at least a cycle)
//   beat_valid   out  a data beat happens this cycle (XFER and granted)
//   beat_last    out  final beat of the burst (qualified by beat_valid)
//   beat_cnt     out  0-based index of the current beat
//   timeout_err  out  one-cycle registered pulse on request timeout
//   busy         out  state is not IDLE
// ---------------------------------------------------------------------------
module arb_requester #(
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 16,
    parameter int GAP      = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat_valid,
    output logic             beat_last,
    output logic [LEN_W-1:0] beat_cnt,
    output logic             timeout_err,
    output logic             busy
);

    // Wait counter only needs to reach MAX_WAIT-1; the gap counter reaches
    // GAP-1 but is sized on GAP+1 so that GAP=1 still gets a 1-bit counter.
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int GAP_W  = $clog2(GAP + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q;
    logic              req_q;
    logic              timeout_err_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;

    logic [LEN_W-1:0]  beat_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_d;
    logic              final_beat;
    logic              wait_expired;
    logic              gap_done;

    // Incremented counter values and the end-of-phase conditions the state
    // machine branches on. Kept outside the FSM so each compare lives in one
    // place.
    always_comb begin
        beat_cnt_d   = beat_cnt_q + 1'b1;
        wait_cnt_d   = wait_cnt_q + 1'b1;
        gap_cnt_d    = gap_cnt_q + 1'b1;
        final_beat   = (beat_cnt_q == len_q);
        wait_expired = (wait_cnt_q == WAIT_LAST);
        gap_done     = (gap_cnt_q == GAP_LAST);
    end

    // Main control FSM. req and timeout_err are registered here so that the
    // arbiter sees a glitch-free request. A grant that arrives in the last
    // wait cycle takes priority over the timeout. In RELEASE the grant is
    // ignored, because the arbiter's registered grant can still be high for
    // a cycle after req has dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            beat_cnt_q    <= '0;
            len_q         <= '0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (job_valid) begin
                        len_q      <= job_len;
                        wait_cnt_q <= '0;
                        req_q      <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (gnt) begin
                        beat_cnt_q <= '0;
                        state_q    <= XFER;
                    end else if (wait_expired) begin
                        timeout_err_q <= 1'b1;
                        req_q         <= 1'b0;
                        gap_cnt_q     <= '0;
                        state_q       <= RELEASE;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                XFER: begin
                    // Without a grant the burst is paused: the index holds
                    // and req stays up.
                    if (gnt) begin
                        if (final_beat) begin
                            beat_cnt_q <= '0;
                            req_q      <= 1'b0;
                            gap_cnt_q  <= '0;
                            state_q    <= RELEASE;
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end
                RELEASE: begin
                    if (gap_done) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs that must react within the cycle: job_ready and busy
    // follow the state, and a beat is tied to the live grant.
    always_comb begin
        job_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);
        beat_valid  = (state_q == XFER) && gnt;
        beat_last   = beat_valid && final_beat;
        beat_cnt    = beat_cnt_q;
        req         = req_q;
        timeout_err = timeout_err_q;
    end

endmodule

// File: tb/tb_arb_requester.sv
// ---------------------------------------------------------------------------
// tb_arb_requester
//
// Two requester instances share a grant source. In manual mode, port 0's
// grant is driven directly by the bench. In arbiter mode, a small registered
// arbiter grants one port at a time. Expected beats are queued when a job is
// offered and checked when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_arb_requester;

    localparam int LEN_W = 4;

    logic             clock;
    logic             reset;
    logic             jobValid0, jobValid1;
    logic [LEN_W-1:0] jobLen0, jobLen1;
    logic             jobReady0, jobReady1;
    logic             req0, req1;
    logic             gnt0, gnt1;
    logic             beatValid0, beatValid1;
    logic             beatLast0, beatLast1;
    logic [LEN_W-1:0] beatCnt0, beatCnt1;
    logic             timeoutErr0, timeoutErr1;
    logic             busy0, busy1;

    logic             arbMode;
    logic             gntMan0;
    logic             gArb0, gArb1;

    int               checkCount = 0;
    int               passCount  = 0;
    int               cyc        = 0;
    int               lastBeat0Cyc;
    int               firstBeat1Cyc;

    // Expected beats, each encoded as last*256 + index.
    int               expQ0[$];
    int               expQ1[$];

    arb_requester #(.LEN_W(LEN_W), .MAX_WAIT(16), .GAP(1)) dut0 (
        .clock(clock), .reset(reset),
        .job_valid(jobValid0), .job_len(jobLen0), .job_ready(jobReady0),
        .req(req0), .gnt(gnt0),
        .beat_valid(beatValid0), .beat_last(beatLast0), .beat_cnt(beatCnt0),
        .timeout_err(timeoutErr0), .busy(busy0)
    );

    arb_requester #(.LEN_W(LEN_W), .MAX_WAIT(16), .GAP(1)) dut1 (
        .clock(clock), .reset(reset),
        .job_valid(jobValid1), .job_len(jobLen1), .job_ready(jobReady1),
        .req(req1), .gnt(gnt1),
        .beat_valid(beatValid1), .beat_last(beatLast1), .beat_cnt(beatCnt1),
        .timeout_err(timeoutErr1), .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Registered arbiter: the owner keeps the grant while it requests, port 0
    // wins when both ask at once. The grant lags req by one cycle on both
    // edges, just like the real arbiter.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            gArb0 <= 1'b0;
            gArb1 <= 1'b0;
        end else if (!arbMode) begin
            gArb0 <= 1'b0;
            gArb1 <= 1'b0;
        end else if (gArb0) begin
            gArb0 <= req0;
        end else if (gArb1) begin
            gArb1 <= req1;
        end else if (req0) begin
            gArb0 <= 1'b1;
        end else if (req1) begin
            gArb1 <= 1'b1;
        end
    end

    assign gnt0 = arbMode ? gArb0 : gntMan0;
    assign gnt1 = arbMode ? gArb1 : 1'b0;

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Offer a job on one port and, if beats are expected, queue them.
    task automatic applyStimulus(input int port, input int len, input bit expectBeats);
        if (port == 0) begin
            jobValid0 = 1'b1;
            jobLen0   = LEN_W'(len);
        end else begin
            jobValid1 = 1'b1;
            jobLen1   = LEN_W'(len);
        end
        if (expectBeats) begin
            for (int b = 0; b <= len; b++) begin
                if (port == 0) expQ0.push_back(((b == len) ? 256 : 0) + b);
                else           expQ1.push_back(((b == len) ? 256 : 0) + b);
            end
        end
    endtask

    task automatic clearJobs();
        jobValid0 = 1'b0;
        jobValid1 = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Beat monitor, sampled on the falling edge. Every beat is checked against
    // the queue, and the two ports must never beat in the same cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (beatValid0) begin
                checkOutput("beat0 expected", int'(expQ0.size() != 0), 1);
                if (expQ0.size() != 0) begin
                    int e;
                    e = expQ0.pop_front();
                    checkOutput("beat0 cnt", int'(beatCnt0), e % 256);
                    checkOutput("beat0 last", int'(beatLast0), e / 256);
                end
                lastBeat0Cyc = cyc;
            end
            if (beatValid1) begin
                checkOutput("beat1 expected", int'(expQ1.size() != 0), 1);
                if (expQ1.size() != 0) begin
                    int e;
                    e = expQ1.pop_front();
                    checkOutput("beat1 cnt", int'(beatCnt1), e % 256);
                    checkOutput("beat1 last", int'(beatLast1), e / 256);
                end
                if (firstBeat1Cyc < 0) firstBeat1Cyc = cyc;
            end
            if (arbMode) checkOutput("dual beat", int'(beatValid0 & beatValid1), 0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        arbMode   = 1'b0;
        gntMan0   = 1'b0;
        jobValid0 = 1'b0;
        jobValid1 = 1'b0;
        jobLen0   = '0;
        jobLen1   = '0;
        lastBeat0Cyc  = -1;
        firstBeat1Cyc = -1;

        // ---- Reset state
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst req", int'(req0), 0);
        checkOutput("rst busy", int'(busy0), 0);
        checkOutput("rst job_ready", int'(jobReady0), 1);
        checkOutput("rst timeout_err", int'(timeoutErr0), 0);
        checkOutput("rst beat_cnt", int'(beatCnt0), 0);

        // ---- Async reset in the middle of a burst
        applyStimulus(0, 3, 1);
        tick();
        clearJobs();
        gntMan0 = 1'b1;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("async req", int'(req0), 0);
        checkOutput("async busy", int'(busy0), 0);
        checkOutput("async beat_valid", int'(beatValid0), 0);
        checkOutput("async timeout_err", int'(timeoutErr0), 0);
        expQ0.delete();
        gntMan0 = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post-rst job_ready", int'(jobReady0), 1);

        // ---- Single job, len=3, grant 2 cycles after req
        applyStimulus(0, 3, 1);
        tick();
        clearJobs();
        checkOutput("t2 req raised", int'(req0), 1);
        checkOutput("t2 job_ready low", int'(jobReady0), 0);
        tick();
        tick();
        gntMan0 = 1'b1;
        #1 checkOutput("t2 no beat in REQ", int'(beatValid0), 0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("t2 last beat", int'(beatLast0), 1);
        tick();
        checkOutput("t2 release req", int'(req0), 0);
        checkOutput("t2 release no beat", int'(beatValid0), 0);
        checkOutput("t2 release not ready", int'(jobReady0), 0);
        gntMan0 = 1'b0;
        tick();
        checkOutput("t2 ready again", int'(jobReady0), 1);
        checkOutput("t2 queue empty", expQ0.size(), 0);

        // ---- Preemption, len=5, grant drops for 3 cycles after beat 2
        applyStimulus(0, 5, 1);
        tick();
        clearJobs();
        gntMan0 = 1'b1;
        tick();
        tick();
        tick();
        tick();
        gntMan0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t3 paused no beat", int'(beatValid0), 0);
            checkOutput("t3 paused req", int'(req0), 1);
            checkOutput("t3 paused cnt", int'(beatCnt0), 3);
            tick();
        end
        gntMan0 = 1'b1;
        tick();
        tick();
        tick();
        gntMan0 = 1'b0;
        checkOutput("t3 release req", int'(req0), 0);
        tick();
        checkOutput("t3 idle", int'(busy0), 0);
        checkOutput("t3 queue empty", expQ0.size(), 0);

        // ---- Timeout, no grant; a late grant in RELEASE is ignored
        applyStimulus(0, 2, 0);
        tick();
        clearJobs();
        for (int i = 1; i <= 16; i++) begin
            checkOutput("t4 waiting req", int'(req0), 1);
            checkOutput("t4 waiting no err", int'(timeoutErr0), 0);
            tick();
        end
        checkOutput("t4 timeout_err", int'(timeoutErr0), 1);
        checkOutput("t4 req dropped", int'(req0), 0);
        gntMan0 = 1'b1;
        #1 checkOutput("t4 grant ignored", int'(beatValid0), 0);
        tick();
        checkOutput("t4 err pulse ends", int'(timeoutErr0), 0);
        checkOutput("t4 back to idle", int'(busy0), 0);
        checkOutput("t4 idle no beat", int'(beatValid0), 0);
        gntMan0 = 1'b0;
        tick();

        // ---- Grant in the final wait cycle beats the timeout
        applyStimulus(0, 0, 1);
        tick();
        clearJobs();
        for (int i = 1; i <= 15; i++) tick();
        gntMan0 = 1'b1;
        tick();
        checkOutput("t5 no timeout", int'(timeoutErr0), 0);
        checkOutput("t5 in xfer req", int'(req0), 1);
        checkOutput("t5 beat", int'(beatValid0), 1);
        tick();
        gntMan0 = 1'b0;
        checkOutput("t5 no late err", int'(timeoutErr0), 0);
        tick();
        checkOutput("t5 idle", int'(busy0), 0);
        checkOutput("t5 queue empty", expQ0.size(), 0);

        // ---- Two ports behind the arbiter, both len=1
        arbMode = 1'b1;
        lastBeat0Cyc  = -1;
        firstBeat1Cyc = -1;
        applyStimulus(0, 1, 1);
        applyStimulus(1, 1, 1);
        tick();
        clearJobs();
        for (int i = 0; i < 40 && (busy0 || busy1); i++) tick();
        checkOutput("t6 both idle", int'(busy0 | busy1), 0);
        checkOutput("t6 queue0 empty", expQ0.size(), 0);
        checkOutput("t6 queue1 empty", expQ1.size(), 0);
        checkOutput("t6 port1 after port0",
                    int'(lastBeat0Cyc >= 0 && firstBeat1Cyc > lastBeat0Cyc), 1);
        checkOutput("t6 no timeout1", int'(timeoutErr1), 0);

        // ---- Reset during an arbitrated burst
        applyStimulus(0, 3, 1);
        tick();
        clearJobs();
        for (int i = 0; i < 20 && !beatValid0; i++) tick();
        checkOutput("t6 burst started", int'(beatValid0), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6 rst req", int'(req0), 0);
        checkOutput("t6 rst busy", int'(busy0), 0);
        checkOutput("t6 rst beat_valid", int'(beatValid0), 0);
        checkOutput("t6 rst beat_cnt", int'(beatCnt0), 0);
        expQ0.delete();
        expQ1.delete();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t6 quiet req", int'(req0 | req1), 0);
        checkOutput("t6 quiet busy", int'(busy0 | busy1), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
